// File: rtl/prefetch_pkg.sv
// Shared types and defaults for the prefetch issuer.
//   addr_t      : default-width address/stride word
//   pf_state_t  : issuer FSM states (IDLE, ISSUE)
package prefetch_pkg;

    localparam int unsigned DEFAULT_ADDR_BITS = 64;
    localparam int unsigned DEFAULT_PAGE_BITS = 12;

    typedef logic [DEFAULT_ADDR_BITS-1:0] addr_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } pf_state_t;

endpackage

// File: rtl/prefetch_issuer_pf_addr_step.sv
// pfAddrStep: combinational address stepper.
// Adds a two's-complement stride to an address (mod 2^ADDR_BITS) and flags when the
// result leaves the given page.
//   addr_i          : base address
//   stride_i        : signed stride
//   page_i          : page number the result must stay within
//   next_o          : addr_i + stride_i, wrapped
//   crosses_page_o  : result outside page_i, or the add wrapped the address space
module pfAddrStep
    import prefetch_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int unsigned PAGE_BITS = DEFAULT_PAGE_BITS
) (
    input  logic [ADDR_BITS-1:0]           addr_i,
    input  logic [ADDR_BITS-1:0]           stride_i,
    input  logic [ADDR_BITS-PAGE_BITS-1:0] page_i,
    output logic [ADDR_BITS-1:0]           next_o,
    output logic                           crosses_page_o
);

    logic [ADDR_BITS:0] sum;
    logic               wrap;

    always_comb begin
        sum  = {1'b0, addr_i} + {1'b0, stride_i};
        // Positive stride wraps on carry-out; negative stride wraps on missing carry (borrow).
        wrap = stride_i[ADDR_BITS-1] ? ~sum[ADDR_BITS] : sum[ADDR_BITS];
        next_o         = sum[ADDR_BITS-1:0];
        crosses_page_o = wrap || (sum[ADDR_BITS-1:PAGE_BITS] != page_i);
    end

endmodule

// File: rtl/prefetch_issuer.sv
// prefetch_issuer: turns (demand access, stride) pairs into bursts of up to DEPTH
// prefetch addresses on a valid/ready port, never leaving the trigger page.
//   clk, reset          : clock, synchronous active-high reset
//   en                  : enables capture of new accesses (does not stall a burst)
//   accessValid/Addr    : demand access
//   stride              : detected stride, 0 = none
//   pfValid/pfAddr      : prefetch request (registered)
//   pfReady             : request accepted
//   busy                : burst in progress
//   issuedCount         : saturating count of accepted requests
module prefetch_issuer
    import prefetch_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PAGE_BITS = DEFAULT_PAGE_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 accessValid,
    input  logic [ADDR_BITS-1:0] accessAddr,
    input  logic [ADDR_BITS-1:0] stride,
    output logic                 pfValid,
    output logic [ADDR_BITS-1:0] pfAddr,
    input  logic                 pfReady,
    output logic                 busy,
    output logic [15:0]          issuedCount
);

    localparam int unsigned PAGE_W = ADDR_BITS - PAGE_BITS;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    pf_state_t            state_q;
    logic [ADDR_BITS-1:0] pf_addr_q;
    logic [ADDR_BITS-1:0] stride_q;
    logic [PAGE_W-1:0]    page_q;
    logic [CNT_W-1:0]     beat_q;
    logic                 pend_valid_q;
    logic [ADDR_BITS-1:0] pend_addr_q;
    logic [ADDR_BITS-1:0] pend_stride_q;
    logic [15:0]          issued_q;

    logic                 trigger;
    logic                 handshake;
    logic [ADDR_BITS-1:0] rs_addr;
    logic [ADDR_BITS-1:0] rs_stride;
    logic [ADDR_BITS-1:0] rs_next;
    logic                 rs_cross;
    logic [ADDR_BITS-1:0] st_next;
    logic                 st_cross;

    assign trigger   = accessValid && en && (stride != '0);
    assign handshake = (state_q == ISSUE) && pfReady;

    // A same-cycle trigger outranks the pending entry as restart source.
    assign rs_addr   = trigger ? accessAddr : pend_addr_q;
    assign rs_stride = trigger ? stride     : pend_stride_q;

    pfAddrStep #(
        .ADDR_BITS (ADDR_BITS),
        .PAGE_BITS (PAGE_BITS)
    ) u_restart_step (
        .addr_i         (rs_addr),
        .stride_i       (rs_stride),
        .page_i         (rs_addr[ADDR_BITS-1:PAGE_BITS]),
        .next_o         (rs_next),
        .crosses_page_o (rs_cross)
    );

    pfAddrStep #(
        .ADDR_BITS (ADDR_BITS),
        .PAGE_BITS (PAGE_BITS)
    ) u_burst_step (
        .addr_i         (pf_addr_q),
        .stride_i       (stride_q),
        .page_i         (page_q),
        .next_o         (st_next),
        .crosses_page_o (st_cross)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pf_addr_q     <= '0;
            stride_q      <= '0;
            page_q        <= '0;
            beat_q        <= '0;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            pend_stride_q <= '0;
            issued_q      <= '0;
        end else begin
            if (handshake && (issued_q != 16'hFFFF)) begin
                issued_q <= issued_q + 16'd1;
            end

            unique case (state_q)
                IDLE: begin
                    if (trigger && !rs_cross) begin
                        state_q   <= ISSUE;
                        pf_addr_q <= rs_next;
                        stride_q  <= rs_stride;
                        page_q    <= rs_addr[ADDR_BITS-1:PAGE_BITS];
                        beat_q    <= CNT_W'(1);
                    end
                end
                ISSUE: begin
                    if (!handshake) begin
                        // Request held stable; newest trigger parks in the pending slot.
                        if (trigger) begin
                            pend_valid_q  <= 1'b1;
                            pend_addr_q   <= accessAddr;
                            pend_stride_q <= stride;
                        end
                    end else if (trigger || pend_valid_q) begin
                        // Preempt: rest of the current burst is discarded.
                        pend_valid_q <= 1'b0;
                        if (rs_cross) begin
                            state_q <= IDLE;
                        end else begin
                            pf_addr_q <= rs_next;
                            stride_q  <= rs_stride;
                            page_q    <= rs_addr[ADDR_BITS-1:PAGE_BITS];
                            beat_q    <= CNT_W'(1);
                        end
                    end else if ((beat_q == DEPTH_CNT) || st_cross) begin
                        state_q <= IDLE;
                    end else begin
                        pf_addr_q <= st_next;
                        beat_q    <= beat_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pfValid     = (state_q == ISSUE);
    assign busy        = (state_q == ISSUE);
    assign pfAddr      = pf_addr_q;
    assign issuedCount = issued_q;

endmodule
